spike_pattern_decoder: RTL

- Readout end of the Hopfield network's spike interface.
- After a start pulse it lets the network settle, then counts rising spike edges per neuron over a fixed window.
- It thresholds each count and presents the recalled pattern with a valid/ready handshake.
- It sits between the network's spike outputs and the host/test logic that applies cue patterns and reads back recall results.

---
 rtl/hopfield_pkg.sv | 16 +
 rtl/spike_edge_counter.sv | 28 ++
 rtl/spike_pattern_decoder.sv | 93 +++++++++
 3 files changed

// File: rtl/hopfield_pkg.sv
// hopfield_pkg: constants and types shared by the Hopfield network and its spike readout
package hopfield_pkg;
  localparam int N_NEURONS   = 7;
  localparam int PATTERN_W   = 4;
  localparam int DEF_SETTLE  = 64;
  localparam int DEF_WINDOW  = 1024;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_THRESH  = 4;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_EVAL,
    ST_HOLD
  } dec_state_t;
endpackage

// File: rtl/spike_edge_counter.sv
// spike_edge_counter: rising-edge detector feeding a saturating event counter for one neuron
module spike_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] count
);
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  always_comb begin
    prev_d  = spike;
    count_d = clr ? '0 : (en && spike && !prev_q && count_q != '1) ? count_q + CNT_W'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
endmodule

// File: rtl/spike_pattern_decoder.sv
// spike_pattern_decoder: settle, count spike edges per neuron over a window, threshold,
// and hand the recalled pattern to the host through valid/ready
module spike_pattern_decoder
  import hopfield_pkg::*;
#(
  parameter int N      = N_NEURONS,
  parameter int P      = PATTERN_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] spikes,
  output logic         busy,
  output logic [P-1:0] pattern_out,
  output logic [N-1:0] active_mask,
  output logic         quiet,
  output logic         pattern_valid,
  input  logic         pattern_ready
);
  localparam int TW = $clog2((SETTLE > WINDOW ? SETTLE : WINDOW) + 1);
  localparam logic [TW-1:0] S_LD = TW'(SETTLE > 0 ? SETTLE - 1 : 0);
  localparam logic [TW-1:0] W_LD = TW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
  dec_state_t       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N-1:0]     active_mask_q, active_mask_d;
  logic             quiet_q, quiet_d;
  logic [N-1:0]     hit, nz;
  logic [CNT_W-1:0] count [N];
  logic             clr, en;
  assign clr = state_q == ST_IDLE && start;
  assign en  = state_q == ST_COUNT;
  for (genvar g = 0; g < N; g++) begin : g_nrn
    spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .en      (en),
      .spike   (spikes[g]),
      .count   (count[g])
    );
    assign hit[g] = count[g] >= TH;
    assign nz[g]  = |count[g];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      active_mask_q <= '0;
      quiet_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      active_mask_q <= active_mask_d;
      quiet_q       <= quiet_d;
    end
  end
  // the timer counts down to zero; a zero-length settle skips straight to counting
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = SETTLE > 0 ? ST_SETTLE : ST_COUNT;
        timer_d = SETTLE > 0 ? S_LD : W_LD;
      end
      ST_SETTLE: begin
        state_d = timer_q == '0 ? ST_COUNT : ST_SETTLE;
        timer_d = timer_q == '0 ? W_LD : timer_q - TW'(1);
      end
      ST_COUNT: begin
        state_d = timer_q == '0 ? ST_EVAL : ST_COUNT;
        timer_d = timer_q == '0 ? '0 : timer_q - TW'(1);
      end
      ST_EVAL: state_d = ST_HOLD;
      ST_HOLD: state_d = pattern_ready ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
    active_mask_d = state_q == ST_EVAL ? hit : active_mask_q;
    quiet_d       = state_q == ST_EVAL ? ~|nz : quiet_q;
  end
  always_comb begin
    busy          = state_q != ST_IDLE;
    pattern_valid = state_q == ST_HOLD;
  end
  assign active_mask = active_mask_q;
  assign pattern_out = active_mask_q[P-1:0];
  assign quiet       = quiet_q;
endmodule
